// File: rtl/move_controller_pkg.sv
// Shared chess definitions for the move controller: piece codes, FSM states,
// button decode encoding and the square-index helper.
package move_controller_pkg;

    // Piece type codes (bits 2:0 of a board nibble); bit 3 is the colour.
    typedef enum logic [2:0] {
        PT_EMPTY  = 3'd0,
        PT_PAWN   = 3'd1,
        PT_KNIGHT = 3'd2,
        PT_BISHOP = 3'd3,
        PT_ROOK   = 3'd4,
        PT_QUEEN  = 3'd5,
        PT_KING   = 3'd6
    } piece_type_t;

    localparam logic [3:0] PIECE_EMPTY = 4'h0;
    localparam int         COLOR_BIT   = 3;

    // Move sequencing states.
    typedef enum logic [2:0] {
        ST_SEL_SRC,
        ST_SEL_DST,
        ST_WR_DST,
        ST_WR_SRC,
        ST_DONE
    } mc_state_t;

    // Button actually acted on in a cycle after priority resolution.
    typedef enum logic [2:0] {
        BTN_NONE,
        BTN_C,
        BTN_U,
        BTN_D,
        BTN_L,
        BTN_R
    } btn_t;

    // Square index {row, col}.
    function automatic logic [5:0] sq(input logic [2:0] r, input logic [2:0] c);
        return {r, c};
    endfunction

endpackage

// File: rtl/move_controller_cursor_ctrl.sv
// cursor_ctrl: resolves simultaneous button pulses (C > U > D > L > R) and
// steps the highlight cursor one square; edges wrap or saturate per CURSOR_WRAP.
module cursor_ctrl
    import move_controller_pkg::*;
#(
    parameter logic [5:0] INIT_CURSOR = 6'd12,
    parameter bit         CURSOR_WRAP = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       i_en,
    input  logic       i_btn_c,
    input  logic       i_btn_u,
    input  logic       i_btn_d,
    input  logic       i_btn_l,
    input  logic       i_btn_r,
    output logic [5:0] o_cursor
);

    logic [2:0] r_row;
    logic [2:0] r_col;
    logic [2:0] w_row_nxt;
    logic [2:0] w_col_nxt;
    btn_t       w_btn;

    // Priority decode: a C pulse consumes the cycle so the cursor holds still.
    always_comb begin
        w_btn = BTN_NONE;
        if      (i_btn_c) w_btn = BTN_C;
        else if (i_btn_u) w_btn = BTN_U;
        else if (i_btn_d) w_btn = BTN_D;
        else if (i_btn_l) w_btn = BTN_L;
        else if (i_btn_r) w_btn = BTN_R;
    end

    // Next row/column with edge handling.
    always_comb begin
        w_row_nxt = r_row;
        w_col_nxt = r_col;
        if (i_en) begin
            case (w_btn)
                BTN_U: if (r_row != 3'd7 || CURSOR_WRAP) w_row_nxt = r_row + 3'd1;
                BTN_D: if (r_row != 3'd0 || CURSOR_WRAP) w_row_nxt = r_row - 3'd1;
                BTN_R: if (r_col != 3'd7 || CURSOR_WRAP) w_col_nxt = r_col + 3'd1;
                BTN_L: if (r_col != 3'd0 || CURSOR_WRAP) w_col_nxt = r_col - 3'd1;
                default: ;
            endcase
        end
    end

    // Cursor register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_row <= INIT_CURSOR[5:3];
            r_col <= INIT_CURSOR[2:0];
        end else begin
            r_row <= w_row_nxt;
            r_col <= w_col_nxt;
        end
    end

    assign o_cursor = sq(r_row, r_col);

endmodule

// File: rtl/move_controller.sv
// move_controller: sequences one chess move on the shared board memory.
// Cursor selects source then destination with BtnC; the controller then writes
// dest <= piece, source <= empty and toggles the side to move.
// Optional build macro MOVE_TURN_ENFORCE_EN: only the side to move may select,
// and selecting an own piece while choosing a destination reselects the source.
module move_controller
    import move_controller_pkg::*;
#(
    parameter logic [5:0] INIT_CURSOR = 6'd12,
    parameter bit         CURSOR_WRAP = 1'b1,
    parameter logic       TURN_INIT   = 1'b0
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic [255:0] board_input,
    input  logic         BtnL,
    input  logic         BtnU,
    input  logic         BtnR,
    input  logic         BtnD,
    input  logic         BtnC,
    input  logic         board_ready,
    output logic         board_we,
    output logic [5:0]   board_out_addr,
    output logic [3:0]   board_out_piece,
    output logic [5:0]   highlight_square_addr,
    output logic [5:0]   select_square_addr,
    output logic         select_valid,
    output logic         turn,
    output logic         move_done
);

    mc_state_t  r_state, w_state_nxt;
    logic [5:0] r_src,    w_src_nxt;
    logic [3:0] r_piece,  w_piece_nxt;
    logic       r_valid,  w_valid_nxt;
    logic       r_turn,   w_turn_nxt;
    logic       r_we,     w_we_nxt;
    logic [5:0] r_addr,   w_addr_nxt;
    logic [3:0] r_wdata,  w_wdata_nxt;
    logic       r_done,   w_done_nxt;

    logic       w_cursor_en;
    logic [3:0] w_cur_piece;
    logic       w_cur_occupied;
    logic       w_selectable;

    assign w_cursor_en    = (r_state == ST_SEL_SRC) || (r_state == ST_SEL_DST);
    assign w_cur_piece    = board_input[{highlight_square_addr, 2'b00} +: 4];
    assign w_cur_occupied = (w_cur_piece != PIECE_EMPTY);

`ifdef MOVE_TURN_ENFORCE_EN
    logic w_cur_own;
    assign w_cur_own    = (w_cur_piece[COLOR_BIT] == r_turn);
    assign w_selectable = w_cur_occupied && w_cur_own;
`else
    assign w_selectable = w_cur_occupied;
`endif

    cursor_ctrl #(
        .INIT_CURSOR (INIT_CURSOR),
        .CURSOR_WRAP (CURSOR_WRAP)
    ) u_cursor (
        .Clk      (Clk),
        .Reset    (Reset),
        .i_en     (w_cursor_en),
        .i_btn_c  (BtnC),
        .i_btn_u  (BtnU),
        .i_btn_d  (BtnD),
        .i_btn_l  (BtnL),
        .i_btn_r  (BtnR),
        .o_cursor (highlight_square_addr)
    );

    // Next state and next registered outputs; write address/data hold by default.
    always_comb begin
        w_state_nxt = r_state;
        w_src_nxt   = r_src;
        w_piece_nxt = r_piece;
        w_valid_nxt = r_valid;
        w_turn_nxt  = r_turn;
        w_we_nxt    = 1'b0;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_SEL_SRC: begin
                if (BtnC && w_selectable) begin
                    w_src_nxt   = highlight_square_addr;
                    w_piece_nxt = w_cur_piece;
                    w_valid_nxt = 1'b1;
                    w_state_nxt = ST_SEL_DST;
                end
            end
            ST_SEL_DST: begin
                if (BtnC) begin
                    if (highlight_square_addr == r_src) begin
                        w_valid_nxt = 1'b0;
                        w_state_nxt = ST_SEL_SRC;
`ifdef MOVE_TURN_ENFORCE_EN
                    end else if (w_selectable) begin
                        w_src_nxt   = highlight_square_addr;
                        w_piece_nxt = w_cur_piece;
`endif
                    end else begin
                        w_we_nxt    = 1'b1;
                        w_addr_nxt  = highlight_square_addr;
                        w_wdata_nxt = r_piece;
                        w_state_nxt = ST_WR_DST;
                    end
                end
            end
            ST_WR_DST: begin
                w_we_nxt = 1'b1;
                if (board_ready) begin
                    w_addr_nxt  = r_src;
                    w_wdata_nxt = PIECE_EMPTY;
                    w_state_nxt = ST_WR_SRC;
                end
            end
            ST_WR_SRC: begin
                w_we_nxt = 1'b1;
                if (board_ready) begin
                    w_we_nxt    = 1'b0;
                    w_done_nxt  = 1'b1;
                    w_turn_nxt  = ~r_turn;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_SEL_SRC;
            end
            default: begin
                w_state_nxt = ST_SEL_SRC;
            end
        endcase
    end

    // State and registered-output flops.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= ST_SEL_SRC;
            r_src   <= '0;
            r_piece <= '0;
            r_valid <= 1'b0;
            r_turn  <= TURN_INIT;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_src   <= w_src_nxt;
            r_piece <= w_piece_nxt;
            r_valid <= w_valid_nxt;
            r_turn  <= w_turn_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign board_we           = r_we;
    assign board_out_addr     = r_addr;
    assign board_out_piece    = r_wdata;
    assign select_square_addr = r_src;
    assign select_valid       = r_valid;
    assign turn               = r_turn;
    assign move_done          = r_done;

endmodule
